sw_pe_cell: RTL and testbench

SW_PE_CELL -- requirements
Module: sw_pe_cell

---
 rtl/sw_pe_cell.sv | 193 +++++++++++++++++++
 tb/tb_sw_pe_cell.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pe_cell.sv
// sw_pe_cell: one Smith-Waterman / Needleman-Wunsch processing-element cell.
// Scores the up/left/diag candidates, keeps the latest and previous scores,
// and tracks the row maximum together with the column it occurred in.
module sw_pe_cell #(
    parameter int SCORE_W  = 8,
    parameter int BASE_W   = 3,
    parameter int POS_W    = 3,
    parameter int COL_W    = 10,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      in_valid_i,
    input  logic                      mode_i,
    input  logic signed [SCORE_W-1:0] up_in_i,
    input  logic signed [SCORE_W-1:0] left_in_i,
    input  logic signed [SCORE_W-1:0] diag_in_i,
    input  logic        [BASE_W-1:0]  ref_base_i,
    input  logic        [BASE_W-1:0]  qry_base_i,
    input  logic        [POS_W-1:0]   pos_up_i,
    input  logic        [POS_W-1:0]   pos_left_i,
    input  logic        [POS_W-1:0]   pos_diag_i,
    input  logic        [COL_W-1:0]   row_len_i,
    output logic                      out_valid_o,
    output logic signed [SCORE_W-1:0] out_current_o,
    output logic signed [SCORE_W-1:0] out_prev_o,
    output logic        [POS_W-1:0]   out_re_pos_o,
    output logic        [1:0]         out_dir_o,
    output logic signed [SCORE_W-1:0] best_score_o,
    output logic        [COL_W-1:0]   best_col_o,
    output logic                      row_done_o
);

    // Candidates carry two guard bits so +/- penalties never wrap before saturation.
    localparam int EW = SCORE_W + 2;

    localparam logic signed [SCORE_W-1:0] SMAX = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] SMIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic signed [EW-1:0] SMAX_E = {3'b000, {(SCORE_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN_E = {3'b111, {(SCORE_W-1){1'b0}}};
    localparam logic signed [EW-1:0] GAP_E      = EW'(GAP);
    localparam logic signed [EW-1:0] MATCH_E    = EW'(MATCH);
    localparam logic signed [EW-1:0] MISMATCH_E = EW'(MISMATCH);
    localparam logic [COL_W-1:0] COL_ONE = {{(COL_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;
    localparam logic [1:0] DIR_DIAG = 2'b11;

    function automatic logic signed [SCORE_W-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SMAX_E) begin
            sat = SMAX;
        end else if (v < SMIN_E) begin
            sat = SMIN;
        end else begin
            sat = v[SCORE_W-1:0];
        end
    endfunction

    logic                      mode_q, mode_d;
    logic        [COL_W-1:0]   row_len_q, row_len_d;
    logic        [COL_W-1:0]   cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic                      row_done_q, row_done_d;
    logic signed [SCORE_W-1:0] cur_q, cur_d;
    logic signed [SCORE_W-1:0] prev_q, prev_d;
    logic        [POS_W-1:0]   re_pos_q, re_pos_d;
    logic        [1:0]         dir_q, dir_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic        [COL_W-1:0]   best_col_q, best_col_d;

    logic signed [EW-1:0]      up_ext, left_ext, diag_ext;
    logic signed [SCORE_W-1:0] up_c, left_c, diag_c;
    logic signed [SCORE_W-1:0] sel_val, score;
    logic        [1:0]         sel_dir, score_dir;
    logic        [POS_W-1:0]   sel_pos, score_pos;

    // Saturated candidates and priority selection (up, then left, then diag), with local-mode clamp.
    always_comb begin
        up_ext   = {{2{up_in_i[SCORE_W-1]}}, up_in_i};
        left_ext = {{2{left_in_i[SCORE_W-1]}}, left_in_i};
        diag_ext = {{2{diag_in_i[SCORE_W-1]}}, diag_in_i};
        up_c     = sat(up_ext - GAP_E);
        left_c   = sat(left_ext - GAP_E);
        diag_c   = (ref_base_i == qry_base_i) ? sat(diag_ext + MATCH_E)
                                              : sat(diag_ext - MISMATCH_E);
        if ((up_c >= left_c) && (up_c >= diag_c)) begin
            sel_val = up_c;
            sel_dir = DIR_UP;
            sel_pos = pos_up_i;
        end else if (left_c >= diag_c) begin
            sel_val = left_c;
            sel_dir = DIR_LEFT;
            sel_pos = pos_left_i;
        end else begin
            sel_val = diag_c;
            sel_dir = DIR_DIAG;
            sel_pos = pos_diag_i;
        end
        // A start in the same cycle brings its own mode, so the cell obeys the new row's mode.
        if (!(start_i ? mode_i : mode_q) && (sel_val < 0)) begin
            score     = '0;
            score_dir = DIR_NONE;
            score_pos = '1;
        end else begin
            score     = sel_val;
            score_dir = sel_dir;
            score_pos = sel_pos;
        end
    end

    logic [COL_W-1:0]          eff_len, eff_cnt, eff_col;
    logic signed [SCORE_W-1:0] eff_best, eff_cur;
    logic                      last_col;

    // Next-state: start clears first, then an accepted cell updates against the cleared state.
    always_comb begin
        eff_len  = start_i ? row_len_i : row_len_q;
        eff_cnt  = start_i ? '0 : cnt_q;
        eff_col  = start_i ? '0 : best_col_q;
        eff_best = start_i ? (mode_i ? SMIN : '0) : best_q;
        eff_cur  = start_i ? '0 : cur_q;
        // A zero row length means the full counter range: wrap only on overflow.
        last_col = (eff_len == '0) ? (&eff_cnt) : (eff_cnt == (eff_len - COL_ONE));

        mode_d     = start_i ? mode_i : mode_q;
        row_len_d  = eff_len;
        cnt_d      = eff_cnt;
        best_d     = eff_best;
        best_col_d = eff_col;
        cur_d      = eff_cur;
        prev_d     = start_i ? '0 : prev_q;
        dir_d      = dir_q;
        re_pos_d   = re_pos_q;
        valid_d    = in_valid_i;
        row_done_d = in_valid_i && last_col;

        if (in_valid_i) begin
            prev_d   = eff_cur;
            cur_d    = score;
            dir_d    = score_dir;
            re_pos_d = score_pos;
            cnt_d    = last_col ? '0 : (eff_cnt + COL_ONE);
            if (score > eff_best) begin
                best_d     = score;
                best_col_d = eff_cnt;
            end
        end
    end

    // State registers; reset aborts any row in progress and returns to local mode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= 1'b0;
            row_len_q  <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            row_done_q <= 1'b0;
            cur_q      <= '0;
            prev_q     <= '0;
            re_pos_q   <= '0;
            dir_q      <= '0;
            best_q     <= '0;
            best_col_q <= '0;
        end else begin
            mode_q     <= mode_d;
            row_len_q  <= row_len_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            row_done_q <= row_done_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            re_pos_q   <= re_pos_d;
            dir_q      <= dir_d;
            best_q     <= best_d;
            best_col_q <= best_col_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_current_o = cur_q;
    assign out_prev_o    = prev_q;
    assign out_re_pos_o  = re_pos_q;
    assign out_dir_o     = dir_q;
    assign best_score_o  = best_q;
    assign best_col_o    = best_col_q;
    assign row_done_o    = row_done_q;

endmodule

// File: tb/tb_sw_pe_cell.sv
// tb_sw_pe_cell: directed bench for sw_pe_cell with a plain-integer reference model.
module tb_sw_pe_cell;

    localparam int SW       = 8;
    localparam int BW       = 3;
    localparam int PW       = 3;
    localparam int CW       = 10;
    localparam int MATCH    = 2;
    localparam int MISMATCH = 1;
    localparam int GAP      = 1;
    localparam int MAXS     = (2 ** (SW - 1)) - 1;
    localparam int MINS     = -(2 ** (SW - 1));

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic startI = 1'b0;
    logic inValid = 1'b0;
    logic modeI = 1'b0;
    logic signed [SW-1:0] upIn = '0;
    logic signed [SW-1:0] leftIn = '0;
    logic signed [SW-1:0] diagIn = '0;
    logic [BW-1:0] refBase = '0;
    logic [BW-1:0] qryBase = '0;
    logic [PW-1:0] posUp = '0;
    logic [PW-1:0] posLeft = '0;
    logic [PW-1:0] posDiag = '0;
    logic [CW-1:0] rowLen = '0;

    logic outValid;
    logic signed [SW-1:0] outCurrent;
    logic signed [SW-1:0] outPrev;
    logic [PW-1:0] outRePos;
    logic [1:0] outDir;
    logic signed [SW-1:0] bestScore;
    logic [CW-1:0] bestCol;
    logic rowDone;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Reference model state, all plain integers.
    int mMode = 0, mLen = 0, mCol = 0, mBest = 0, mBestCol = 0;
    int mCur = 0, mPrev = 0, mDir = 0, mPos = 0, mValid = 0, mRowDone = 0;

    sw_pe_cell #(
        .SCORE_W(SW), .BASE_W(BW), .POS_W(PW), .COL_W(CW),
        .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(startI), .in_valid_i(inValid),
        .mode_i(modeI), .up_in_i(upIn), .left_in_i(leftIn), .diag_in_i(diagIn),
        .ref_base_i(refBase), .qry_base_i(qryBase),
        .pos_up_i(posUp), .pos_left_i(posLeft), .pos_diag_i(posDiag),
        .row_len_i(rowLen),
        .out_valid_o(outValid), .out_current_o(outCurrent), .out_prev_o(outPrev),
        .out_re_pos_o(outRePos), .out_dir_o(outDir),
        .best_score_o(bestScore), .best_col_o(bestCol), .row_done_o(rowDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int satM(input int v);
        if (v > MAXS) return MAXS;
        if (v < MINS) return MINS;
        return v;
    endfunction

    task automatic modelReset();
        mMode = 0; mLen = 0; mCol = 0; mBest = 0; mBestCol = 0;
        mCur = 0; mPrev = 0; mDir = 0; mPos = 0; mValid = 0; mRowDone = 0;
    endtask

    // One clock edge of the cell, computed straight from the scoring rules.
    task automatic modelStep(input bit st, input bit v, input bit md, input int u, input int l,
                             input int d, input bit eq, input int pu, input int pl, input int pd,
                             input int len);
        int cu, cl, cd, mx, sc, dr, ps, lenEff;
        if (st) begin
            mMode = md; mLen = len; mCol = 0; mBestCol = 0;
            mBest = md ? MINS : 0; mCur = 0; mPrev = 0;
        end
        mValid = v;
        mRowDone = 0;
        if (v) begin
            cu = satM(u - GAP);
            cl = satM(l - GAP);
            cd = eq ? satM(d + MATCH) : satM(d - MISMATCH);
            mx = cu;
            if (cl > mx) mx = cl;
            if (cd > mx) mx = cd;
            if (cu == mx) begin dr = 1; ps = pu; end
            else if (cl == mx) begin dr = 2; ps = pl; end
            else begin dr = 3; ps = pd; end
            sc = mx;
            if (mMode == 0 && mx < 0) begin
                sc = 0; dr = 0; ps = (1 << PW) - 1;
            end
            mPrev = mCur; mCur = sc; mDir = dr; mPos = ps;
            if (sc > mBest) begin
                mBest = sc; mBestCol = mCol;
            end
            lenEff = (mLen == 0) ? (1 << CW) : mLen;
            if (mCol == lenEff - 1) begin
                mRowDone = 1; mCol = 0;
            end else begin
                mCol++;
            end
        end
    endtask

    // Drive one cycle of inputs, step the model past the edge, return at the next falling edge.
    task automatic applyStimulus(input bit st, input bit v, input bit md, input int u, input int l,
                                 input int d, input int refB, input int qryB, input int pu,
                                 input int pl, input int pd, input int len);
        startI = st; inValid = v; modeI = md;
        upIn = SW'(u); leftIn = SW'(l); diagIn = SW'(d);
        refBase = BW'(refB); qryBase = BW'(qryB);
        posUp = PW'(pu); posLeft = PW'(pl); posDiag = PW'(pd);
        rowLen = CW'(len);
        @(posedge clk);
        #1;
        modelStep(st, v, md, u, l, d, (refB == qryB), pu, pl, pd, len);
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, int'(outValid), 0);
        checkOutput({tag, ".cur"}, int'(outCurrent), 0);
        checkOutput({tag, ".prev"}, int'(outPrev), 0);
        checkOutput({tag, ".dir"}, int'(outDir), 0);
        checkOutput({tag, ".pos"}, int'(outRePos), 0);
        checkOutput({tag, ".best"}, int'(bestScore), 0);
        checkOutput({tag, ".bestCol"}, int'(bestCol), 0);
        checkOutput({tag, ".rowDone"}, int'(rowDone), 0);
    endtask

    // Every falling edge the DUT outputs must agree with the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp.valid", int'(outValid), mValid);
            checkOutput("cmp.cur", int'(outCurrent), mCur);
            checkOutput("cmp.prev", int'(outPrev), mPrev);
            checkOutput("cmp.dir", int'(outDir), mDir);
            checkOutput("cmp.pos", int'(outRePos), mPos);
            checkOutput("cmp.best", int'(bestScore), mBest);
            checkOutput("cmp.bestCol", int'(bestCol), mBestCol);
            checkOutput("cmp.rowDone", int'(rowDone), mRowDone);
        end
    end

    initial begin
        $display("[TB] sw_pe_cell bench starting");
        #2;
        checkAllZero("por");
        #10 rstN = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);

        // Idle after reset: nothing valid yet.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("idle.valid", int'(outValid), 0);

        // Local row of four cells.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        checkOutput("start.best", int'(bestScore), 0);
        applyStimulus(0, 1, 0, 3, 2, 4, 2, 2, 1, 2, 5, 0);
        checkOutput("match.cur", int'(outCurrent), 6);
        checkOutput("match.dir", int'(outDir), 3);
        checkOutput("match.pos", int'(outRePos), 5);
        applyStimulus(0, 1, 0, 5, 5, 4, 1, 2, 4, 2, 5, 0);
        checkOutput("tie.cur", int'(outCurrent), 4);
        checkOutput("tie.dir", int'(outDir), 1);
        checkOutput("tie.prev", int'(outPrev), 6);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 2, 4, 2, 5, 0);
        checkOutput("clamp.cur", int'(outCurrent), 0);
        checkOutput("clamp.dir", int'(outDir), 0);
        checkOutput("clamp.pos", int'(outRePos), 7);
        applyStimulus(0, 1, 0, 0, 0, 127, 3, 3, 1, 2, 6, 0);
        checkOutput("satHi.cur", int'(outCurrent), 127);
        checkOutput("satHi.rowDone", int'(rowDone), 1);
        checkOutput("satHi.bestCol", int'(bestCol), 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("hold.cur", int'(outCurrent), 127);
        checkOutput("hold.rowDone", int'(rowDone), 0);

        // Global row, start and cell in the same cycle, row_len 0.
        applyStimulus(1, 1, 1, -128, -128, -128, 1, 2, 6, 2, 3, 0);
        checkOutput("satLo.cur", int'(outCurrent), -128);
        checkOutput("satLo.dir", int'(outDir), 1);
        checkOutput("satLo.prev", int'(outPrev), 0);
        checkOutput("satLo.best", int'(bestScore), -128);
        applyStimulus(0, 1, 1, 10, 0, 0, 1, 2, 1, 2, 3, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("gap.valid", int'(outValid), 0);
        applyStimulus(0, 1, 1, 0, 0, 20, 4, 4, 1, 2, 3, 0);
        checkOutput("b2b.prev", int'(outPrev), 9);
        checkOutput("b2b.cur", int'(outCurrent), 22);
        // Mode input changes without start: still global, no clamp.
        applyStimulus(0, 1, 0, -50, -50, -50, 1, 2, 1, 2, 3, 0);
        checkOutput("modeHold.cur", int'(outCurrent), -51);
        checkOutput("modeHold.best", int'(bestScore), 22);
        checkOutput("modeHold.bestCol", int'(bestCol), 2);

        // Row 1,5,5,2 then a wrap into the next row.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        applyStimulus(0, 1, 0, 2, 0, -10, 0, 1, 1, 2, 3, 0);
        applyStimulus(0, 1, 0, 6, 0, -10, 0, 1, 1, 2, 3, 0);
        applyStimulus(0, 1, 0, 6, 0, -10, 0, 1, 1, 2, 3, 0);
        checkOutput("row.rowDoneEarly", int'(rowDone), 0);
        applyStimulus(0, 1, 0, 3, 0, -10, 0, 1, 1, 2, 3, 0);
        checkOutput("row.best", int'(bestScore), 5);
        checkOutput("row.bestCol", int'(bestCol), 1);
        checkOutput("row.rowDone", int'(rowDone), 1);
        applyStimulus(0, 1, 0, 10, 0, -10, 0, 1, 1, 2, 3, 0);
        checkOutput("wrap.best", int'(bestScore), 9);
        checkOutput("wrap.bestCol", int'(bestCol), 0);

        // One-cell row with start and cell together.
        applyStimulus(1, 1, 0, 4, 0, 0, 0, 1, 1, 2, 3, 1);
        checkOutput("len1.rowDone", int'(rowDone), 1);
        checkOutput("len1.prev", int'(outPrev), 0);
        checkOutput("len1.best", int'(bestScore), 3);

        // Asynchronous reset in the middle of a row.
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        applyStimulus(0, 1, 1, 3, 0, 0, 0, 1, 1, 2, 3, 0);
        applyStimulus(0, 1, 1, 4, 0, 0, 0, 1, 1, 2, 3, 0);
        startI = 0; inValid = 0;
        @(posedge clk);
        #1;
        modelStep(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rstN = 1'b0;
        modelReset();
        #1;
        checkAllZero("async");
        @(negedge clk);
        @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkOutput("postRst.valid", int'(outValid), 0);
        applyStimulus(0, 1, 0, 8, 0, 0, 0, 1, 1, 2, 3, 0);
        checkOutput("postRst.prev", int'(outPrev), 0);
        checkOutput("postRst.cur", int'(outCurrent), 7);
        checkOutput("postRst.rowDone", int'(rowDone), 0);
        applyStimulus(0, 1, 1, -50, -50, -50, 0, 1, 1, 2, 3, 0);
        checkOutput("postRst.localClamp", int'(outCurrent), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
